// File: rtl/circl_span.sv
// circl_span: sequential circle-span generator.
// Each request computes half_w = isqrt(R*R - dy*dy) for a filled circle of
// radius R on the scanline at vertical offset dy. One root bit per clock.
//
// Ports:
//   i_clk     system clock
//   i_rst_n   synchronous active-low reset
//   i_start   request strobe, sampled only while idle
//   i_radius  circle radius R, captured with i_start
//   i_dy      |vertical offset| from centre, captured with i_start
//   o_busy    high while a request is in flight (CALC/SQRT/DONE)
//   o_done    one-cycle pulse; o_half_w and o_inside are updated this cycle
//   o_inside  1 when dy <= R
//   o_half_w  span half-width, held until the next o_done
module circl_span #(
  parameter int unsigned W     = 5,
  parameter int unsigned ROUND = 0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [W-1:0] i_radius,
  input  logic [W-1:0] i_dy,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_inside,
  output logic [W-1:0] o_half_w
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_SQRT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [CW-1:0] CNT_TOP = CW'(W - 1);

  logic [1:0]     r_state;
  logic [W-1:0]   r_radius;
  logic [W-1:0]   r_dy;
  logic           r_in_r;
  logic [2*W-1:0] r_x;
  logic [W:0]     r_rem;
  logic [W-1:0]   r_root;
  logic [CW-1:0]  r_cnt;
  logic           r_busy;
  logic           r_done;
  logic           r_inside;
  logic [W-1:0]   r_half_w;

  // Radicand: R*R - dy*dy, forced to zero when the scanline misses the circle.
  logic [2*W-1:0] w_r_sq;
  logic [2*W-1:0] w_dy_sq;
  logic [2*W-1:0] w_x;
  logic           w_in_r;

  assign w_r_sq  = {{W{1'b0}}, r_radius} * {{W{1'b0}}, r_radius};
  assign w_dy_sq = {{W{1'b0}}, r_dy} * {{W{1'b0}}, r_dy};
  assign w_in_r  = (r_dy <= r_radius);
  assign w_x     = w_in_r ? (w_r_sq - w_dy_sq) : '0;

  // One restoring step: bring down the next radicand bit pair and try to
  // subtract 4q+1. The accepted remainder always fits in W+1 bits, so the
  // subtraction is done at that width.
  logic [W+2:0] w_rem_sh;
  logic [W+2:0] w_trial;
  logic         w_ge;
  logic [W:0]   w_diff;
  logic [W:0]   w_rem_nxt;
  logic [W-1:0] w_root_nxt;

  assign w_rem_sh   = {r_rem, r_x[2*W-1 -: 2]};
  assign w_trial    = {1'b0, r_root, 2'b01};
  assign w_ge       = (w_rem_sh >= w_trial);
  assign w_diff     = w_rem_sh[W:0] - w_trial[W:0];
  assign w_rem_nxt  = w_ge ? w_diff : w_rem_sh[W:0];
  assign w_root_nxt = {r_root[W-2:0], w_ge};

  // Round to nearest: sqrt(x) >= q + 1/2 exactly when x - q*q > q.
  logic         w_round_up;
  logic [W:0]   w_sum;
  logic [W-1:0] w_half_w;

  assign w_round_up = (ROUND != 0) && (w_rem_nxt > {1'b0, w_root_nxt});
  assign w_sum      = {1'b0, w_root_nxt} + {{W{1'b0}}, w_round_up};
  assign w_half_w   = w_sum[W] ? '1 : w_sum[W-1:0];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_radius <= '0;
      r_dy     <= '0;
      r_in_r   <= 1'b0;
      r_x      <= '0;
      r_rem    <= '0;
      r_root   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_inside <= 1'b0;
      r_half_w <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_radius <= i_radius;
            r_dy     <= i_dy;
            r_busy   <= 1'b1;
            r_state  <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_in_r  <= w_in_r;
          r_x     <= w_x;
          r_rem   <= '0;
          r_root  <= '0;
          r_cnt   <= CNT_TOP;
          r_state <= ST_SQRT;
        end
        ST_SQRT: begin
          r_x    <= {r_x[2*W-3:0], 2'b00};
          r_rem  <= w_rem_nxt;
          r_root <= w_root_nxt;
          if (r_cnt == '0) begin
            // Last step: publish the result so it is visible in the DONE cycle.
            r_done   <= 1'b1;
            r_half_w <= w_half_w;
            r_inside <= r_in_r;
            r_state  <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_inside = r_inside;
  assign o_half_w = r_half_w;

endmodule

// File: tb/tb_circl_span.sv
// tb_circl_span: self-checking bench for circl_span (W=5), ROUND=0 and ROUND=1
// instances driven in parallel. A cycle-level reference model predicts busy,
// done, half_w and inside; directed requests pin the model with literals.
module tb_circl_span;

  localparam int W    = 5;
  localparam int MAXV = (1 << W) - 1;
  localparam int LAT  = W + 2;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b0;
  logic         start  = 1'b0;
  logic [W-1:0] radius = '0;
  logic [W-1:0] dy     = '0;

  logic         busy0, done0, inside0;
  logic [W-1:0] hw0;
  logic         busy1, done1, inside1;
  logic [W-1:0] hw1;

  circl_span #(.W(W), .ROUND(0)) u_dut0 (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_radius (radius),
    .i_dy     (dy),
    .o_busy   (busy0),
    .o_done   (done0),
    .o_inside (inside0),
    .o_half_w (hw0)
  );

  circl_span #(.W(W), .ROUND(1)) u_dut1 (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_radius (radius),
    .i_dy     (dy),
    .o_busy   (busy1),
    .o_done   (done1),
    .o_inside (inside1),
    .o_half_w (hw1)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Span half-width straight from the definition: largest q with q*q <= x.
  function automatic int model_hw(input int r, input int d, input int rnd);
    int x;
    int q;
    if (d > r) return 0;
    x = r * r - d * d;
    q = 0;
    while ((q + 1) * (q + 1) <= x) q++;
    if (rnd != 0 && (x - q * q) > q) q++;
    if (q > MAXV) q = MAXV;
    return q;
  endfunction

  // Reference model: a request is accepted when idle, busy for LAT cycles,
  // done on the last of them.
  bit m_active = 1'b0;
  int m_cnt    = 0;
  int m_p0, m_p1, m_pin;
  int m_hw0    = 0;
  int m_hw1    = 0;
  int m_in     = 0;
  int m_busy   = 0;
  int m_done   = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_hw0    = 0;
      m_hw1    = 0;
      m_in     = 0;
      m_done   = 0;
    end else if (m_active) begin
      m_cnt++;
      m_done = (m_cnt == LAT - 1) ? 1 : 0;
      if (m_done != 0) begin
        m_hw0 = m_p0;
        m_hw1 = m_p1;
        m_in  = m_pin;
      end
      if (m_cnt == LAT) m_active = 1'b0;
    end else if (start) begin
      m_active = 1'b1;
      m_cnt    = 0;
      m_p0     = model_hw(int'(radius), int'(dy), 0);
      m_p1     = model_hw(int'(radius), int'(dy), 1);
      m_pin    = (dy <= radius) ? 1 : 0;
      m_done   = 0;
    end
    m_busy = m_active ? 1 : 0;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy0", int'(busy0), m_busy);
      check("busy1", int'(busy1), m_busy);
      check("done0", int'(done0), m_done);
      check("done1", int'(done1), m_done);
      check("half_w0", int'(hw0), m_hw0);
      check("half_w1", int'(hw1), m_hw1);
      check("inside0", int'(inside0), m_in);
      check("inside1", int'(inside1), m_in);
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy0; i++) @(negedge clk);
  endtask

  // Issue one request, check latency and both results against literals/model.
  task automatic do_req(input int r, input int d, input int e0, input int e1, input int ein,
                        input string tag);
    int lat;
    bit got;
    wait_idle();
    start  = 1'b1;
    radius = r[W-1:0];
    dy     = d[W-1:0];
    lat    = 0;
    got    = 1'b0;
    for (int i = 1; i <= LAT + 4; i++) begin
      @(negedge clk);
      start  = 1'b0;
      radius = W'($urandom);
      dy     = W'($urandom);
      if (done0) begin
        lat = i;
        got = 1'b1;
        break;
      end
    end
    check({tag, " latency"}, lat, LAT);
    if (got) begin
      check({tag, " half_w r0"}, int'(hw0), e0);
      check({tag, " half_w r1"}, int'(hw1), e1);
      check({tag, " inside"}, int'(inside0), ein);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done;
    int n_low;
    int hw_a;
    int hw_b;

    repeat (2) @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    check("reset busy", int'(busy0), 0);
    check("reset half_w", int'(hw0), 0);
    check("reset inside", int'(inside0), 0);
    rst_n = 1'b1;

    check("model isqrt57 r0", model_hw(11, 8, 0), 7);
    check("model isqrt57 r1", model_hw(11, 8, 1), 8);

    do_req(31, 0, 31, 31, 1, "t1 r31 d0");
    do_req(10, 8, 6, 6, 1, "t2 r10 d8");
    do_req(10, 10, 0, 0, 1, "t2 r10 d10");
    do_req(10, 11, 0, 0, 0, "t2 r10 d11");
    do_req(11, 8, 7, 8, 1, "t3 r11 d8");
    do_req(9, 5, 7, 7, 1, "t3 r9 d5");
    do_req(0, 0, 0, 0, 1, "r0 d0");
    do_req(31, 31, 0, 0, 1, "r31 d31");

    // Starts during busy are ignored; one idle cycle, then a new start is taken.
    wait_idle();
    start  = 1'b1;
    radius = 10;
    dy     = 6;
    n_done = 0;
    n_low  = 0;
    hw_a   = 0;
    hw_b   = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (done0) begin
        n_done++;
        if (n_done == 1) hw_a = int'(hw0);
        else hw_b = int'(hw0);
      end
      if (!busy0) n_low++;
      start = ((i >= 2 && i <= 5) || i == 8);
      if (start) begin
        radius = 3;
        dy     = 0;
      end else begin
        radius = W'($urandom);
        dy     = W'($urandom);
      end
    end
    check("t4 done count", n_done, 2);
    check("t4 first half_w", hw_a, 8);
    check("t4 second half_w", hw_b, 3);
    check("t4 busy low cycles", n_low, 1);

    // Reset mid-SQRT aborts the request without a done.
    wait_idle();
    start  = 1'b1;
    radius = 10;
    dy     = 8;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5 busy", int'(busy0), 0);
    check("t5 half_w", int'(hw0), 0);
    check("t5 inside", int'(inside0), 0);
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done0 || done1) n_done++;
    end
    check("t5 no done", n_done, 0);
    do_req(5, 3, 4, 4, 1, "t5 r5 d3");

    for (int r = 0; r <= MAXV; r++) begin
      for (int d = 0; d <= MAXV; d++) begin
        do_req(r, d, model_hw(r, d, 0), model_hw(r, d, 1), (d <= r) ? 1 : 0, "sweep");
      end
    end

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start  = ($urandom_range(0, 2) == 0);
      radius = W'($urandom);
      dy     = W'($urandom);
      rst_n  = ($urandom_range(0, 199) != 0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
